// File: rtl/spi_stream_pkg.sv
// Shared types and constants for the SPI stream scheduler.
// Optional checksum word is enabled with SPI_STREAM_SCHED_CHECKSUM_EN.
package spi_stream_pkg;

  localparam int unsigned SEQ_W       = 16;
  localparam int unsigned HDR_TAG_LSB = 8;
  localparam int unsigned HDR_ID_LSB  = 0;
  localparam logic [7:0]  HDR_MAGIC_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StSeq,
    StPayload,
    StHalt
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
    , StCsum
`endif
  } sched_state_e;

  // Header layout: {tag, 4'h0, source id}
  function automatic logic [15:0] make_header(input logic [7:0] tag, input logic [3:0] id);
    logic [15:0] h;
    h = '0;
    h[HDR_TAG_LSB +: 8] = tag;
    h[HDR_ID_LSB +: 4]  = id;
    return h;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first requester at or after last_grant+1 (mod N_SRC).
module rr_arbiter #(
  parameter int unsigned N_SRC = 4
) (
  input  logic [N_SRC-1:0] req,
  input  logic [3:0]       last_grant,
  output logic [N_SRC-1:0] gnt_onehot,
  output logic [3:0]       gnt_idx,
  output logic             gnt_valid
);

  logic [15:0] req_pad;
  logic [5:0]  cand;

  assign req_pad = 16'(req);

  always_comb begin
    gnt_idx   = '0;
    gnt_valid = 1'b0;
    cand      = '0;
    for (int k = 0; k < N_SRC; k++) begin
      // last_grant < N_SRC and k < N_SRC, so one wrap subtraction suffices
      cand = 6'(last_grant) + 6'(k) + 6'd1;
      if (cand >= 6'(N_SRC)) cand = cand - 6'(N_SRC);
      if (!gnt_valid && req_pad[cand[3:0]]) begin
        gnt_valid = 1'b1;
        gnt_idx   = cand[3:0];
      end
    end
    gnt_onehot = gnt_valid ? N_SRC'(16'b1 << gnt_idx) : '0;
  end

endmodule

// File: rtl/spi_stream_scheduler.sv
// Round-robin packet scheduler framing SPI source data onto the shared stream port.
// Define SPI_STREAM_SCHED_CHECKSUM_EN to append an XOR checksum word to each packet.
module spi_stream_scheduler
  import spi_stream_pkg::*;
#(
  parameter int unsigned N_SRC     = 4,
  parameter int unsigned PKT_WORDS = 32,
  parameter logic [7:0]  HDR_MAGIC = HDR_MAGIC_DEFAULT
) (
  input  logic                  dataclk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  stream_overflow,
  input  logic [N_SRC-1:0]      src_req,
  input  logic [N_SRC*16-1:0]   src_data,
  output logic [N_SRC-1:0]      src_rden,
  output logic [15:0]           FIFO_DATA_STREAM,
  output logic                  FIFO_DATA_STREAM_WEN,
  output logic [3:0]            grant_id,
  output logic                  busy,
  output logic                  halted,
  output logic [31:0]           pkt_count
);

  localparam int unsigned CntW = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(PKT_WORDS - 1);

  sched_state_e     state_q;
  logic [3:0]       last_grant_q;
  logic [N_SRC-1:0] grant_oh_q;
  logic [SEQ_W-1:0] seq_num_q;
  logic [CntW-1:0]  cnt_q;
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
  logic [15:0]      csum_q;
`endif

  logic [N_SRC-1:0] arb_onehot;
  logic [3:0]       arb_idx;
  logic             arb_valid;
  logic [15:0]      src_words [16];

  rr_arbiter #(
    .N_SRC (N_SRC)
  ) u_arb (
    .req        (src_req),
    .last_grant (last_grant_q),
    .gnt_onehot (arb_onehot),
    .gnt_idx    (arb_idx),
    .gnt_valid  (arb_valid)
  );

  // Pad the source bus to 16 lanes so the 4-bit grant index selects safely.
  for (genvar g = 0; g < 16; g++) begin : gen_words
    if (g < N_SRC) begin : gen_used
      assign src_words[g] = src_data[16*g +: 16];
    end else begin : gen_pad
      assign src_words[g] = '0;
    end
  end

  always_ff @(posedge dataclk or posedge reset) begin
    if (reset) begin
      state_q              <= StIdle;
      FIFO_DATA_STREAM     <= '0;
      FIFO_DATA_STREAM_WEN <= 1'b0;
      grant_id             <= '0;
      grant_oh_q           <= '0;
      last_grant_q         <= 4'(N_SRC - 1);
      seq_num_q            <= '0;
      cnt_q                <= '0;
      pkt_count            <= '0;
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
      csum_q               <= '0;
`endif
    end else begin
      FIFO_DATA_STREAM_WEN <= 1'b0;
      if (stream_overflow && (state_q != StHalt)) begin
        // Abandon any partial packet; nothing further is written.
        state_q <= StHalt;
      end else begin
        case (state_q)
          StIdle: begin
            if (enable && arb_valid) begin
              state_q    <= StHdr;
              grant_id   <= arb_idx;
              grant_oh_q <= arb_onehot;
            end
          end
          StHdr: begin
            FIFO_DATA_STREAM     <= make_header(HDR_MAGIC, grant_id);
            FIFO_DATA_STREAM_WEN <= 1'b1;
            cnt_q                <= '0;
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
            csum_q               <= '0;
`endif
            state_q              <= StSeq;
          end
          StSeq: begin
            FIFO_DATA_STREAM     <= seq_num_q;
            FIFO_DATA_STREAM_WEN <= 1'b1;
            seq_num_q            <= seq_num_q + 1'b1;
            state_q              <= StPayload;
          end
          StPayload: begin
            FIFO_DATA_STREAM     <= src_words[grant_id];
            FIFO_DATA_STREAM_WEN <= 1'b1;
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
            csum_q               <= csum_q ^ src_words[grant_id];
`endif
            if (cnt_q == CntLast) begin
              cnt_q <= '0;
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
              state_q <= StCsum;
`else
              state_q      <= StIdle;
              pkt_count    <= pkt_count + 1'b1;
              last_grant_q <= grant_id;
`endif
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
`ifdef SPI_STREAM_SCHED_CHECKSUM_EN
          StCsum: begin
            FIFO_DATA_STREAM     <= csum_q;
            FIFO_DATA_STREAM_WEN <= 1'b1;
            state_q              <= StIdle;
            pkt_count            <= pkt_count + 1'b1;
            last_grant_q         <= grant_id;
          end
`endif
          StHalt: begin
            if (!stream_overflow) state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Pop strobe decoded only from registered state, so it clears with async reset.
  always_comb begin
    src_rden = '0;
    if (state_q == StPayload) src_rden = grant_oh_q;
  end

  assign busy   = (state_q != StIdle);
  assign halted = (state_q == StHalt);

endmodule
